serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial adder for WIDTH-bit operands with carry-in. One full-adder cell plus a carry flip-flop process one bit per clock, LSB first.
- Sits directly downstream of the structural half-adder cell: it builds its full-adder slice from two half-adders and adds the sequencing around it.
- Used as the lab's first sequential arithmetic stage, with a start/done handshake.

Parameters:
- WIDTH, 4, operand and sum width in bits (legal range 2..16).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request a new addition; sampled only in IDLE
- a  input  WIDTH  operand A, captured on the accepting edge
- b  input  WIDTH  operand B, captured on the accepting edge
- cin  input  1  carry-in, captured on the accepting edge
- busy  output  1  high while in SHIFT or DONE
- done  output  1  one-cycle pulse: sum/cout valid
- sum  output  WIDTH  registered result, held until the next completion
- cout  output  1  registered final carry, held with sum

Behaviour:
- Reset (rst_n low, any time, asynchronous):
  - state=IDLE; shift registers, counter and carry flop cleared.
  - busy=0, done=0, sum=0, cout=0.
  - A reset mid-operation abandons the addition; no done is produced.
- States: IDLE, SHIFT, DONE. Encoding is a 2-bit state register.
- IDLE:
  - start=1 at an edge: capture a->areg, b->breg, cin->carry; clear cnt; go to SHIFT.
  - start=0: stay in IDLE.
- SHIFT (one bit per edge):
  - Compute s_bit, c_bit = FA(areg[0], breg[0], carry).
  - Shift sreg right with s_bit entering at the MSB; shift areg and breg right (zero fill).
  - carry <= c_bit; cnt <= cnt+1.
  - On the edge where cnt==WIDTH-1: sum <= final sreg value (including this bit), cout <= c_bit, go to DONE.
- DONE: done=1 for exactly this one cycle, then go to IDLE unconditionally on the next edge.
- Latency: start sampled at edge E0; done is high in the cycle after edge E0+WIDTH; the block is back in IDLE after edge E0+WIDTH+1.
- start handling:
  - Ignored while busy, including during DONE; a held-high start is re-accepted on the first IDLE edge.
  - Back-to-back throughput is one result per WIDTH+2 cycles.
- Output timing:
  - sum/cout change only at the completion edge or on reset.
  - Intermediate partial sums are never visible on sum.
- Overflow: the result is modulo 2^WIDTH on sum; bit WIDTH goes to cout. There is no separate overflow flag.
- a, b and cin may change freely while busy; they have no effect until the next accept.
- cnt width is clog2(WIDTH), and it does not wrap past WIDTH-1 within an operation.

Decomposition:
- Shared package/include serial_adder_defs:
  - State encodings ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2.
  - Default WIDTH constant.
  - ST_DONE+1 (2'd3) is illegal and recovers to IDLE.
- One sub-module, fa_bit: a full adder built from two instances of the existing structural half-adder plus an OR for the carry.
- Registers and the FSM stay in serial_adder.

Test Plan:
- Reset then 0+0, cin=0 -> done pulse exactly 5 cycles after the start edge (WIDTH=4); sum=0000, cout=0; busy high for 5 cycles.
- 5+3, cin=0 -> sum=1000, cout=0. Then 15+1 -> sum=0000, cout=1. Then 15+15, cin=1 -> sum=1111, cout=1.
- start pulsed again 2 cycles into an operation with different a/b -> ignored; result matches the first operands; exactly one done pulse.
- start held high continuously with 6+7 -> done every 6 cycles, sum=1101, cout=0 each time; sum stable between pulses.
- rst_n low mid-SHIFT (after 2 bits) -> busy, done, sum and cout go to 0 immediately; no done follows. A new 9+9 after release gives sum=0010, cout=1.
- Exhaustive sweep of all a, b, cin for WIDTH=4, checked against {cout,sum}==a+b+cin; rerun the 15+1 case with WIDTH=8 (sum=00010000, cout=0, done at 9 cycles).

Source files
------------

// File: rtl/serial_adder_pkg.sv
// ============================================================================
// Module  : serial_adder_defs (package)
// Brief   : State encodings and default width shared by the serial adder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_adder_defs;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/half_adder.sv
// ============================================================================
// Module  : half_adder
// Brief   : Structural half-adder cell (sum = a ^ b, carry = a & b).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

`default_nettype wire

// File: rtl/serial_adder_fa_bit.sv
// ============================================================================
// Module  : fa_bit
// Brief   : Full-adder slice built from two half-adders and an OR for carry.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic w_s1;
  logic w_c1;
  logic w_c2;

  half_adder u_ha0 (.a(a),    .b(b),   .s(w_s1), .c(w_c1));
  half_adder u_ha1 (.a(w_s1), .b(cin), .s(s),    .c(w_c2));

  assign cout = w_c1 | w_c2;

endmodule

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
// Module  : serial_adder
// Brief   : Bit-serial WIDTH-bit adder, LSB first, with start/done handshake.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder
  import serial_adder_defs::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int             CW     = $clog2(WIDTH);
  localparam logic [CW-1:0]  C_LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_areg;
  logic [WIDTH-1:0] r_breg;
  logic [WIDTH-1:0] r_sreg;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [CW-1:0]    r_cnt;
  logic             w_s_bit;
  logic             w_c_bit;
  logic             w_accept;
  logic             w_last;

  fa_bit u_fa (
    .a   (r_areg[0]),
    .b   (r_breg[0]),
    .cin (r_carry),
    .s   (w_s_bit),
    .cout(w_c_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    busy     = 1'b0;
    done     = 1'b0;
    w_accept = 1'b0;
    w_last   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        busy = 1'b1;
        if (r_cnt == C_LAST) begin
          w_last = 1'b1;
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      // The unused 2'd3 code falls back to IDLE.
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_areg  <= '0;
      r_breg  <= '0;
      r_sreg  <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_areg  <= a;
      r_breg  <= b;
      r_carry <= cin;
      r_sreg  <= '0;
      r_cnt   <= '0;
    end else if (r_state == ST_SHIFT) begin
      r_sreg  <= {w_s_bit, r_sreg[WIDTH-1:1]};
      r_areg  <= r_areg >> 1;
      r_breg  <= r_breg >> 1;
      r_carry <= w_c_bit;
      // Counter parks at the last index; sum/cout only move on this edge.
      if (w_last) begin
        r_sum  <= {w_s_bit, r_sreg[WIDTH-1:1]};
        r_cout <= w_c_bit;
      end else begin
        r_cnt  <= r_cnt + 1'b1;
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
// Module  : tb_serial_adder
// Brief   : Scoreboard bench for serial_adder (WIDTH=4 and WIDTH=8 instances).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_adder;

  localparam int W  = 4;
  localparam int W8 = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  logic          start8 = 1'b0;
  logic [W8-1:0] a8 = '0;
  logic [W8-1:0] b8 = '0;
  logic          cin8 = 1'b0;
  logic          busy8, done8, cout8;
  logic [W8-1:0] sum8;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_adder #(.WIDTH(W8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [W-1:0]  sum; logic cout; int e0; } exp4_t;
  typedef struct { logic [W8-1:0] sum; logic cout; int e0; } exp8_t;
  exp4_t q4[$];
  exp8_t q8[$];
  exp4_t e4;
  exp8_t e8;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t",
                  name, got, got, exp, exp, $time);
  endtask

  // Monitor for the WIDTH=4 instance: pops on done, otherwise checks hold.
  logic [W:0] last4 = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      last4 = '0;
    end else if (done) begin
      if (q4.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e4 = q4.pop_front();
        chk("sum", int'(sum), int'(e4.sum));
        chk("cout", int'(cout), int'(e4.cout));
        chk("done_latency", cyc - e4.e0 + 1, W + 1);
      end
      last4 = {cout, sum};
    end else begin
      chk("sum_hold", int'({cout, sum}), int'(last4));
    end
  end

  always @(negedge clk) begin
    if (rst_n && done8) begin
      if (q8.size() == 0) begin
        chk("unexpected_done8", 1, 0);
      end else begin
        e8 = q8.pop_front();
        chk("sum8", int'(sum8), int'(e8.sum));
        chk("cout8", int'(cout8), int'(e8.cout));
        chk("done_latency8", cyc - e8.e0 + 1, W8 + 1);
      end
    end
  end

  // Issue one addition; optionally pulse a second start mid-operation.
  task automatic do_add(input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input logic xc, input logic [W-1:0] es,
                        input logic ec, input int inject_at);
    int n;
    n = 0;
    @(negedge clk);
    a = xa; b = xb; cin = xc; start = 1'b1;
    q4.push_back('{es, ec, cyc + 1});
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0; a = ~xa; b = ~xb; cin = ~xc;
      end
      if (inject_at != 0 && k == inject_at) begin
        start = 1'b1; a = 4'd9; b = 4'd9;
      end
      if (inject_at != 0 && k == inject_at + 1) start = 1'b0;
      if (busy) n++;
      else if (n > 0) break;
    end
    chk("busy_cycles", n, W + 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int s;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_sum",  int'(sum),  0);
    chk("rst_cout", int'(cout), 0);
    chk("rst_busy8", int'(busy8), 0);
    @(negedge clk); #2 rst_n = 1'b1;

    do_add(4'd0,  4'd0,  1'b0, 4'b0000, 1'b0, 0);
    do_add(4'd5,  4'd3,  1'b0, 4'b1000, 1'b0, 0);
    do_add(4'd15, 4'd1,  1'b0, 4'b0000, 1'b1, 0);
    do_add(4'd15, 4'd15, 1'b1, 4'b1111, 1'b1, 0);
    // Second start 2 cycles in must be ignored.
    do_add(4'd2,  4'd3,  1'b0, 4'b0101, 1'b0, 2);

    // Held-high start: one result every WIDTH+2 cycles.
    @(negedge clk);
    a = 4'd6; b = 4'd7; cin = 1'b0; start = 1'b1;
    base = cyc + 1;
    for (int k = 0; k < 3; k++) q4.push_back('{4'b1101, 1'b0, base + 6 * k});
    repeat (13) @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    repeat (2) @(negedge clk);
    chk("held_drain", q4.size(), 0);

    // Reset after two bits have been shifted.
    @(negedge clk);
    a = 4'd5; b = 4'd6; cin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_sum",  int'(sum),  0);
    chk("midrst_cout", int'(cout), 0);
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("midrst_idle", int'(busy), 0);
    do_add(4'd9, 4'd9, 1'b0, 4'b0010, 1'b1, 0);

    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        for (int ic = 0; ic < 2; ic++) begin
          s = ia + ib + ic;
          do_add(4'(ia), 4'(ib), 1'(ic), 4'(s), 1'(s >> 4), 0);
        end

    @(negedge clk);
    a8 = 8'd15; b8 = 8'd1; cin8 = 1'b0; start8 = 1'b1;
    q8.push_back('{8'b0001_0000, 1'b0, cyc + 1});
    @(negedge clk); start8 = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (q8.size() == 0) break;
    end
    chk("dut8_drain", q8.size(), 0);

    repeat (3) @(negedge clk);
    chk("q4_empty", q4.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
